// File: rtl/response_misr.sv
// Response compactor: folds valid samples of a benchmark output vector into a MISR
// over a programmable window and compares against a golden signature.
// Optional build macro MISR_STICKY_EN makes the mismatch flag sticky until reset.
module response_misr #(
  parameter int                 WIDTH = 11,
  parameter logic [WIDTH-1:0]   POLY  = WIDTH'(5),
  parameter int                 CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] sig_nxt;
  logic             accept;
  logic             last_smp;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] r);
    return {s[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{s[WIDTH-1]}}) ^ r;
  endfunction

  // Combine a fresh compare result with the previous flag value.
  function automatic logic merge_flag(input logic prev, input logic fail);
`ifdef MISR_STICKY_EN
    return prev | fail;
`else
    return fail;
`endif
  endfunction

  // Flag value on an accepted start of a non-empty window.
  function automatic logic start_flag(input logic prev);
`ifdef MISR_STICKY_EN
    return prev;
`else
    return 1'b0 & prev;
`endif
  endfunction

  assign sig_nxt  = misr_step(signature, resp);
  assign accept   = (state == RUN) && resp_valid;
  // cnt < len always holds in RUN, so cnt+1 never wraps even for len = 2^CNT_W-1.
  assign last_smp = accept && ((cnt + CNT_W'(1)) == len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (window_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_smp) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      signature <= '0;
      cnt       <= '0;
      len       <= '0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            signature <= '0;
            cnt       <= '0;
            len       <= window_len;
            if (window_len == '0) begin
              mismatch <= merge_flag(mismatch, golden != '0);
            end else begin
              mismatch <= start_flag(mismatch);
            end
          end
        end
        RUN: begin
          if (accept) begin
            signature <= sig_nxt;
            cnt       <= cnt + CNT_W'(1);
            if (last_smp) begin
              mismatch <= merge_flag(mismatch, sig_nxt != golden);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_misr.sv
// Self-checking bench for response_misr: polynomial-arithmetic reference model,
// per-cycle output compare, directed windows with literal signatures, random windows.
module tb_response_misr;
  localparam int W  = 11;
  localparam int CW = 16;
`ifdef MISR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] window_len = '0;
  logic [W-1:0]  golden = '0;
  logic          resp_valid = 1'b0;
  logic [W-1:0]  resp = '0;
  logic          busy, done, mismatch;
  logic [W-1:0]  signature;

  always #5 clk = ~clk;

  response_misr dut (
    .clk(clk), .reset(reset), .start(start), .window_len(window_len),
    .golden(golden), .resp_valid(resp_valid), .resp(resp),
    .busy(busy), .done(done), .signature(signature), .mismatch(mismatch)
  );

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Signature arithmetic: multiply by x modulo x^11+x^2+1, then add the sample.
  function automatic logic [W-1:0] mstep(input logic [W-1:0] s, input logic [W-1:0] r);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ 12'h805;
    return t[W-1:0] ^ r;
  endfunction

  // Reference model: a window is either closed, open with samples remaining, or just finished.
  bit          m_open = 1'b0;
  bit          m_fin  = 1'b0;
  bit          m_mis  = 1'b0;
  logic [W-1:0] m_sig = '0;
  int          m_rem  = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_open = 1'b0; m_fin = 1'b0; m_mis = 1'b0; m_sig = '0; m_rem = 0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_open) begin
      if (resp_valid) begin
        m_sig = mstep(m_sig, resp);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_open = 1'b0;
          m_fin  = 1'b1;
          m_mis  = (STICKY & m_mis) | (m_sig != golden);
        end
      end
    end else if (start) begin
      m_sig = '0;
      m_rem = int'(window_len);
      if (m_rem == 0) begin
        m_fin = 1'b1;
        m_mis = (STICKY & m_mis) | (golden != '0);
      end else begin
        m_open = 1'b1;
        m_mis  = STICKY & m_mis;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_open);
      chk("done", done, m_fin);
      chk("signature", signature, m_sig);
      chk("mismatch", mismatch, m_mis);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic begin_win(input int len, input logic [W-1:0] g);
    start = 1'b1; window_len = len[CW-1:0]; golden = g;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] r, input int stall);
    repeat (stall) begin
      resp_valid = 1'b0; resp = W'($urandom); start = 1'($urandom_range(0, 1));
      cyc();
    end
    start = 1'b0; resp_valid = 1'b1; resp = r;
    cyc();
    resp_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] smp [$];
    logic [W-1:0] pred;
    logic [W-1:0] g;
    int len;

    cyc(); cyc();
    chk_en = 1'b1;
    chk("reset_sig", signature, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mis", mismatch, 0);
    reset = 1'b1;
    cyc();

    // Single sample; a start held during the done cycle is ignored.
    begin_win(1, 11'h123);
    send(11'h123, 0);
    chk("t1_done", done, 1);
    chk("t1_sig", signature, 11'h123);
    chk("t1_mis", mismatch, 0);
    start = 1'b1; window_len = 16'd3;
    cyc();
    start = 1'b0;
    chk("t1_ignored_start", busy, 0);
    cyc();

    // Feedback: the seed bit reaches the top after 11 samples and folds back on the 12th.
    begin_win(11, 11'h400);
    send(11'h001, 0);
    repeat (10) send(11'h000, 0);
    chk("t2a_sig", signature, 11'h400);
    chk("t2a_mis", mismatch, 0);
    cyc();
    begin_win(12, 11'h400);
    send(11'h001, 0);
    repeat (11) send(11'h000, 0);
    chk("t2b_sig", signature, 11'h005);
    chk("t2b_mis", mismatch, 1);
    cyc();

    // Stalls before the only sample.
    begin_win(1, 11'h123);
    repeat (5) begin
      resp_valid = 1'b0; resp = 11'h7ff;
      cyc();
      chk("t3_stall_busy", busy, 1);
    end
    send(11'h123, 0);
    chk("t3_done", done, 1);
    chk("t3_sig", signature, 11'h123);
    cyc();

    // Empty window.
    begin_win(0, 11'h000);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_mis", mismatch, 0);
    cyc();

    // Reset mid-window, then reset colliding with start, then a clean window.
    begin_win(4, 11'h000);
    send(11'h155, 0);
    send(11'h2aa, 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t5_sig", signature, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_mis", mismatch, 0);
    reset = 1'b0; start = 1'b1; window_len = 16'd2;
    cyc();
    reset = 1'b1; start = 1'b0;
    chk("t5_rst_wins", busy, 0);
    pred = mstep(mstep(mstep(mstep(11'h0, 11'h011), 11'h022), 11'h044), 11'h088);
    begin_win(4, pred);
    send(11'h011, 0); send(11'h022, 1); send(11'h044, 0); send(11'h088, 2);
    chk("t5_done2", done, 1);
    chk("t5_mis2", mismatch, 0);
    cyc();

    // Failing window followed by a passing one.
    begin_win(1, 11'h002);
    send(11'h001, 0);
    chk("t6_fail", mismatch, 1);
    cyc();
    begin_win(1, 11'h00f);
    send(11'h00f, 0);
    chk("t6_after_pass", mismatch, STICKY);
    cyc();

    // Random windows with stalls, ignored starts and idle noise.
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 6);
      smp.delete();
      pred = '0;
      for (int i = 0; i < len; i++) begin
        smp.push_back(W'($urandom));
        pred = mstep(pred, smp[i]);
      end
      g = ($urandom_range(0, 1) == 1) ? pred : W'($urandom);
      begin_win(len, g);
      foreach (smp[i]) send(smp[i], $urandom_range(0, 2));
      chk("rand_done", done, 1);
      chk("rand_sig", signature, pred);
      cyc();
      repeat ($urandom_range(0, 2)) begin
        resp_valid = 1'b1; resp = W'($urandom);
        cyc();
      end
      resp_valid = 1'b0;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
